cms_and_pipe: RTL
=================

# cms_and_pipe

Parametrised, pipelined masked AND gadget in the consolidated-masking style. It multiplies two Boolean-shared operands of SHARES shares per bit, across WIDTH independent bit lanes. Each cross-product is refreshed with ring randomness, registered, then compressed into SHARES output shares. A valid/ready handshake with full backpressure lets the block sit inside masked datapaths (S-box pipelines, masked ALUs) that are evaluated under SILVER.

## Interface
Parameters:
- SHARES, 4, number of shares per bit (≥2)
- WIDTH, 1, number of independent bit lanes

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand shares and randomness valid
- in_ready  output  1  stage 1 can accept this cycle
- a  input  SHARES*WIDTH  operand A shares; lane l, share i at bit l*SHARES+i
- b  input  SHARES*WIDTH  operand B shares, same packing
- refreshing  input  SHARES*SHARES*WIDTH  fresh randomness; lane l, term k at bit l*SHARES*SHARES+k
- out_valid  output  1  c holds a result
- out_ready  input  1  consumer accepts c
- c  output  SHARES*WIDTH  product shares, same packing as a

## Operation
- Per lane l, let N=SHARES and M=N*N. Each term index k=i*N+j, for i,j in 0..N-1.
- Stage 1 (combinational into registers): t_k = (a_i & b_j) ^ r_k ^ r_((k+1) mod M), with r taken from that lane's slice of refreshing. This is ring refresh: every r bit enters exactly two terms.
- Stage 1 registers: M*WIDTH term bits plus s1_valid.
- Stage 2 compression: c_j = XOR over i of the registered t_(i*N+j). Compression is computed only from stage-1 register outputs; no unregistered input reaches the XOR tree.
- Stage 2 registers: c (N*WIDTH bits) plus s2_valid. c is driven directly from flops.
- Correctness: XOR of c shares = (XOR of a shares) & (XOR of b shares) per lane, for any refreshing value.
- Handshake:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
- Stage 1 captures a, b and refreshing only on in_valid & in_ready. Otherwise the stage-1 term registers hold. s1_valid <= in_valid when s1_adv.
- Stage 2 captures when s2_adv. s2_valid <= s1_valid; term data are compressed into c only when s1_valid, otherwise c holds.
- While stalled, no register recomputes. Refreshing is don't-care whenever no capture occurs, and randomness is never reused across two captures.
- Reset (async, rst_n low): s1_valid=0, s2_valid=0, all term registers=0, c=0.
- Outputs during reset: out_valid=0, in_ready=1.

## Timing
- Latency 2: an operand accepted at the end of cycle 0 produces out_valid=1 with c valid in cycle 2.
- Throughput: one operation per cycle while out_ready=1.
- in_ready is combinational from out_ready. This is the only combinational input-to-output path; out_valid and c are purely registered.
- Full pipeline (s1_valid=s2_valid=1) with out_ready=0: in_ready=0, and all state holds indefinitely.
- Simultaneous events:
  - With out_ready=1 in a full pipeline, in_ready=1. Stage 2 takes stage 1 and stage 1 takes the new input on the same edge.
  - With stage 1 empty and stage 2 stalled, stage 1 still accepts one operand.
- Mid-operation reset drops all in-flight results. out_valid is 0 on the first edge after rst_n deasserts, and no stale c is presented.
- The ring index wraps: term M-1 uses r_(M-1) and r_0.

## Test plan
- Reset defaults: hold rst_n=0 with random inputs → out_valid=0, c=0, in_ready=1. Release rst_n; no out_valid without an accepted in_valid.
- Basic product (N=4, W=1): a=4'b1011, b=4'b0001, refreshing=16'h0000, single accept → c=4'b0001 in cycle 2, out_valid pulse of 1 cycle. Repeat with refreshing=16'hA5C3 → XOR of c = 1.
- Exhaustive unmasked values: for all unmasked a,b ∈{0,1} with 200 random share splits and random refreshing, streamed back-to-back with out_ready=1 → XOR of c equals a&b, and results emerge in order at 1 per cycle.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles while driving changing a/b/refreshing → in_ready=0, c and term registers are unchanged. On release, both results emerge in order with no loss or duplication.
- Multi-lane (N=3, W=8): random shared bytes → per-lane XOR of c equals bitwise AND of the unmasked bytes, and no cross-lane randomness is used.
- Reset mid-flight: assert rst_n low with both stages valid → out_valid drops asynchronously, and after release no old result appears.

Source files
------------

// File: rtl/cms_and_pipe.sv
// -----------------------------------------------------------------------------
// cms_and_pipe
//
// Two-stage pipelined masked AND gadget in the consolidated-masking style.
// Each lane multiplies two Boolean-shared bits of SHARES shares. All
// SHARES*SHARES cross products are ring-refreshed and registered. They are
// then compressed column-wise into SHARES output shares, which are also
// registered. A valid/ready handshake provides full backpressure.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand shares and randomness are valid
//   in_ready    stage 1 can accept this cycle (combinational from out_ready)
//   a, b        operand shares; lane l, share i at bit l*SHARES+i
//   refreshing  fresh randomness; lane l, term k at bit l*SHARES*SHARES+k
//   out_valid   c holds a result
//   out_ready   consumer accepts c
//   c           product shares, same packing as a
// -----------------------------------------------------------------------------
module cms_and_pipe #(
    parameter int SHARES = 4,
    parameter int WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SHARES*WIDTH-1:0]          a,
    input  logic [SHARES*WIDTH-1:0]          b,
    input  logic [SHARES*SHARES*WIDTH-1:0]   refreshing,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SHARES*WIDTH-1:0]          c
);

    localparam int N = SHARES;
    localparam int M = SHARES * SHARES;

    logic [M*WIDTH-1:0] w_terms;
    logic [M*WIDTH-1:0] r_terms;
    logic [N*WIDTH-1:0] w_comp;
    logic [N*WIDTH-1:0] r_c;
    logic               r_s1_valid;
    logic               r_s2_valid;
    logic               w_s1_adv;
    logic               w_s2_adv;
    logic               w_s1_load;

    // A stage advances when it is empty or when its downstream advances.
    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign w_s1_load = in_valid && w_s1_adv;

    // Ring refresh: term k takes r_k and r_(k+1 mod M), so every random bit
    // enters exactly two terms and cancels in the XOR of all output shares.
    // Randomness is strictly lane-local.
    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        for (genvar i = 0; i < N; i++) begin : g_row
            for (genvar j = 0; j < N; j++) begin : g_col
                localparam int K  = i * N + j;
                localparam int KN = (K + 1) % M;
                assign w_terms[l*M+K] = (a[l*N+i] & b[l*N+j])
                                      ^ refreshing[l*M+K]
                                      ^ refreshing[l*M+KN];
            end
        end
    end

    // Column compression reads only registered terms, so no glitchy input
    // path reaches the XOR tree.
    always_comb begin
        // NOTE: default first so this combinational block can never infer a latch.
        w_comp = '0;
        for (int l = 0; l < WIDTH; l++) begin
            for (int j = 0; j < N; j++) begin
                for (int i = 0; i < N; i++) begin
                    w_comp[l*N+j] = w_comp[l*N+j] ^ r_terms[l*M+i*N+j];
                end
            end
        end
    end

    // Stage 1: term registers load only on an accepted operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            // NOTE: the term array is reset as well, so no share material from
            // an aborted operation survives a reset.
            r_terms    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample pre-edge values.
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_load) begin
                r_terms <= w_terms;
            end
        end
    end

    // Stage 2: compressed shares load only when stage 1 holds a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_c        <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_c <= w_comp;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign c         = r_c;

endmodule
